apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
Synthesizable APB3 slave that terminates transfers issued by the testbench APB master interface. It provides a general-purpose register bank, a programmable wait-state generator and PSLVERR error signalling. It exercises the master's setup/access/PREADY-polling path and exposes the register contents to downstream logic.

Parameters:
NUM_REGS, 16, number of 32-bit RW general registers (1..64)
BASE_ADDR, 32'h0000_0000, byte base address of the block
DEFAULT_WAIT, 4'd0, reset value of WAIT_CFG (wait states per transfer)
ID_VALUE, 32'hA9B0_0001, constant returned by the ID register

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
PADDR  in  32  byte address
PWRITE  in  1  1=write, 0=read
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWDATA  in  32  write data
PRDATA  out  32  read data, valid only while PREADY=1
PREADY  out  1  transfer complete (registered)
PSLVERR  out  1  error, valid only while PREADY=1 (registered)
reg_out  out  32*NUM_REGS  flattened general registers, reg i at [32*i+31:32*i]

Behaviour:
- One clock (PCLK). Reset is synchronous and active-high (PRESET).
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, all general regs=0, WAIT_CFG=DEFAULT_WAIT, WR_COUNT=0, FSM=IDLE, wait counter=0. Reset mid-transfer abandons the transfer with no register update.
- Address map, offset = PADDR-BASE_ADDR:
  - 0x000+4*i, i<NUM_REGS: REG[i], RW.
  - 0x100: WAIT_CFG, RW, bits[3:0], upper bits read 0.
  - 0x104: WR_COUNT, RO, counts successful writes, wraps 0xFFFF_FFFF->0.
  - 0x108: ID, RO, =ID_VALUE.
- Errors, all give PSLVERR=1: PADDR[1:0]!=0; offset unmapped (including REG index >=NUM_REGS); write to RO register. On error: no state change, PRDATA=0, WR_COUNT unchanged.
- FSM IDLE / WAIT / DONE:
  - IDLE: PSEL=1 & PENABLE=0 -> load cnt=WAIT_CFG, go WAIT.
  - WAIT: PSEL=0 -> abort, go IDLE, no effect.
  - WAIT, PSEL&PENABLE & cnt!=0 -> cnt--.
  - WAIT, PSEL&PENABLE & cnt==0 -> at this edge: perform write or capture read, set PREADY=1, drive PRDATA/PSLVERR, go DONE.
  - DONE: next edge PREADY=0, PSLVERR=0, PRDATA=0. If PSEL=1 & PENABLE=0 on that edge (back-to-back), load cnt and go WAIT; else go IDLE.
- Latency: first edge sampling PSEL&PENABLE = A. PREADY is high in the cycle after edge A+WAIT_CFG, for exactly one cycle.
- WAIT_CFG is sampled at setup. A write to WAIT_CFG takes effect from the next transfer, never the current one.
- Read-after-write in consecutive transfers returns the new value. A read of REG[i] in the same transfer as nothing else sees the current register contents.
- PADDR/PWRITE/PWDATA are sampled at the completion edge. They must be stable per the APB protocol, and no internal copy is kept.
- reg_out updates one cycle after the completion edge of a write.
- PENABLE=1 while in IDLE (protocol violation): ignored, stays IDLE, PREADY stays 0.

Test Plan:
- Reset then read 0x108 -> PRDATA=0xA9B00001, PSLVERR=0. Read REG[3] -> 0.
- WAIT_CFG=0: write 0x0C<=0xDEADBEEF, then read 0x0C -> 0xDEADBEEF. PREADY high one cycle after the first access edge. reg_out[127:96]=0xDEADBEEF. WR_COUNT=1.
- Write 0x100<=5, then time a read of 0x00 -> PREADY rises 5 cycles later than with WAIT_CFG=0. The write to 0x100 itself completes with 0 waits.
- Error cases, each -> PSLVERR=1, state unchanged, WR_COUNT unchanged:
  - write 0x104<=7
  - read 0x0FC with NUM_REGS=16
  - write 0x02
- PSEL dropped during WAIT with WAIT_CFG=3 on a write of 0x1234 to REG[0] -> REG[0] unchanged, FSM returns to IDLE. A following read returns 0.
- Assert PRESET during WAIT of a write -> PREADY=0, regs and WAIT_CFG return to reset values. After PRESET deasserts, the next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB3 slave register bank with programmable wait states and PSLVERR.
// Holds NUM_REGS RW registers, a wait-state config, a write counter and a constant ID word.
module apb_slave_regbank #(
  parameter int          NUM_REGS     = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [3:0]  DEFAULT_WAIT = 4'd0,
  parameter logic [31:0] ID_VALUE     = 32'hA9B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [31:0]             PADDR,
  input  logic                    PWRITE,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [32*NUM_REGS-1:0]  reg_out
);

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt, wait_cfg;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] wr_count, offset, reg_rd, rd_data;
  logic        hit_reg, err, complete, wr_ok;

  // Address decode runs on the live bus; the result is only used at the completion edge.
  always_comb begin
    offset  = PADDR - BASE_ADDR;
    hit_reg = (offset[31:8] == 24'd0) && ({1'b0, offset[7:2]} < NUM_REGS_W);
    reg_rd  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (offset[7:2] == i[5:0]) reg_rd = regs[i];
    end
    rd_data = '0;
    err     = 1'b0;
    if (PADDR[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (hit_reg) begin
      rd_data = reg_rd;
    end else if (offset == 32'h100) begin
      rd_data = {28'd0, wait_cfg};
    end else if (offset == 32'h104) begin
      rd_data = wr_count;
      err     = PWRITE;
    end else if (offset == 32'h108) begin
      rd_data = ID_VALUE;
      err     = PWRITE;
    end else begin
      err = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          next_state = ST_WAIT;
          next_cnt   = wait_cfg;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          next_state = ST_IDLE;
        end else if (PENABLE) begin
          if (cnt != 4'd0) begin
            next_cnt = cnt - 4'd1;
          end else begin
            complete   = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (PSEL && !PENABLE) begin
          next_state = ST_WAIT;
          next_cnt   = wait_cfg;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign wr_ok = complete && PWRITE && !err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
      wait_cfg <= DEFAULT_WAIT;
      wr_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      PREADY  <= complete;
      PSLVERR <= complete && err;
      PRDATA  <= (complete && !err && !PWRITE) ? rd_data : 32'd0;
      if (wr_ok) begin
        wr_count <= wr_count + 32'd1;
        if (offset == 32'h100) wait_cfg <= PWDATA[3:0];
        for (int i = 0; i < NUM_REGS; i++) begin
          if (hit_reg && offset[7:2] == i[5:0]) regs[i] <= PWDATA;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - directed scoreboard bench for apb_slave_regbank.
// A reference model predicts each transfer's result when it is issued; results are popped on PREADY.
module tb_apb_slave_regbank;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic         PSEL;
  logic         PENABLE;
  logic [31:0]  PWDATA;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [511:0] reg_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_regs [16];
  logic [3:0]  model_wait;
  logic [31:0] model_cnt;
  bit          rw;
  logic [3:0]  ridx;
  logic [31:0] rdat;

  apb_slave_regbank dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .reg_out (reg_out)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    model_wait = 4'd0;
    model_cnt  = 32'd0;
  endfunction

  function automatic void predict(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit er);
    rd = 32'd0;
    er = 1'b0;
    if (a[1:0] != 2'b00) er = 1'b1;
    else if (a < 32'h40) begin
      if (wr) model_regs[a[5:2]] = wd;
      else    rd = model_regs[a[5:2]];
    end else if (a == 32'h100) begin
      if (wr) model_wait = wd[3:0];
      else    rd = {28'd0, model_wait};
    end else if (a == 32'h104) begin
      if (wr) er = 1'b1;
      else    rd = model_cnt;
    end else if (a == 32'h108) begin
      if (wr) er = 1'b1;
      else    rd = 32'hA9B0_0001;
    end else er = 1'b1;
    if (wr && !er) model_cnt = model_cnt + 32'd1;
    if (wr || er) rd = 32'd0;
  endfunction

  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t        e;
    logic [31:0] rd;
    bit          er;
    int          lat;
    bit          done;
    e.lat = int'(model_wait);
    predict(wr, a, wd, rd, er);
    e.tag   = tag;
    e.rdata = rd;
    e.err   = er;
    sb.push_back(e);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 64) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else        lat++;
    end
    e = sb.pop_front();
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s timeout: PREADY not seen, expected after %0d waits", e.tag, e.lat);
    end
    if (done) begin
      chk({e.tag, " prdata"}, PRDATA, e.rdata);
      chk({e.tag, " pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
      chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk({e.tag, " pready one cycle"}, {31'd0, PREADY}, 32'd0);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    model_reset();
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("reset pready", {31'd0, PREADY}, 32'd0);
    chk("reset pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("reset prdata", PRDATA, 32'd0);
    chk_wide("reset reg_out", reg_out, model_flat());

    apb_xfer(1'b0, 32'h108, 32'd0, "rd id");
    apb_xfer(1'b0, 32'h00C, 32'd0, "rd reg3 init");

    apb_xfer(1'b1, 32'h00C, 32'hDEAD_BEEF, "wr reg3");
    apb_xfer(1'b0, 32'h00C, 32'd0, "rd reg3");
    chk("reg_out reg3", reg_out[127:96], 32'hDEAD_BEEF);
    apb_xfer(1'b0, 32'h104, 32'd0, "rd wr_count 1");

    apb_xfer(1'b1, 32'h100, 32'd5, "wr wait_cfg 5");
    apb_xfer(1'b0, 32'h000, 32'd0, "rd reg0 wait5");
    apb_xfer(1'b0, 32'h100, 32'd0, "rd wait_cfg");

    apb_xfer(1'b1, 32'h104, 32'd7, "err wr wr_count");
    apb_xfer(1'b0, 32'h0FC, 32'd0, "err rd 0xfc");
    apb_xfer(1'b1, 32'h002, 32'h55, "err misaligned wr");
    apb_xfer(1'b0, 32'h10C, 32'd0, "err rd 0x10c");
    apb_xfer(1'b0, 32'h104, 32'd0, "rd wr_count after errs");
    apb_xfer(1'b0, 32'h00C, 32'd0, "rd reg3 after errs");
    chk_wide("reg_out after errs", reg_out, model_flat());

    // Abandon a write while its wait states are still counting down.
    apb_xfer(1'b1, 32'h100, 32'd3, "wr wait_cfg 3");
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h000; PWRITE = 1'b1; PWDATA = 32'h1234;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort pready in wait", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("abort pready after", {31'd0, PREADY}, 32'd0);
    chk("abort reg0", reg_out[31:0], model_regs[0]);
    apb_xfer(1'b0, 32'h000, 32'd0, "rd reg0 after abort");

    apb_xfer(1'b1, 32'h100, 32'd1, "wr wait_cfg 1");
    for (int i = 0; i < 10; i++) begin
      rw   = 1'($urandom_range(0, 1));
      ridx = 4'($urandom_range(0, 15));
      rdat = $urandom;
      apb_xfer(rw, {26'd0, ridx, 2'b00}, rdat, "rand reg");
    end
    chk_wide("reg_out after rand", reg_out, model_flat());
    apb_xfer(1'b0, 32'h104, 32'd0, "rd wr_count after rand");

    // Reset in the middle of a waited write: nothing from it may land.
    apb_xfer(1'b1, 32'h100, 32'd3, "wr wait_cfg 3 again");
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h004; PWRITE = 1'b1; PWDATA = 32'hAAAA;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("mid reset pready", {31'd0, PREADY}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
    @(negedge PCLK);
    chk_wide("mid reset reg_out", reg_out, model_flat());
    apb_xfer(1'b0, 32'h100, 32'd0, "rd wait_cfg after reset");
    apb_xfer(1'b0, 32'h104, 32'd0, "rd wr_count after reset");
    apb_xfer(1'b1, 32'h004, 32'h0055_AA00, "wr reg1 after reset");
    apb_xfer(1'b0, 32'h004, 32'd0, "rd reg1 after reset");
    chk("reg_out reg1", reg_out[63:32], 32'h0055_AA00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
